// File: rtl/axi_lite_lsu_if.sv
// rtl/axi_lite_lsu_if.sv - request/response and AXI4-lite bundle for the load/store unit
// master is the LSU side; slave is the core plus the external AXI memory.
interface axi_lite_lsu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [1:0]              req_size;
  logic                    req_signed;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    resp_valid;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic                    resp_err;

  logic                    axi_awvalid;
  logic                    axi_awready;
  logic [ADDR_WIDTH-1:0]   axi_awaddr;
  logic [2:0]              axi_awprot;
  logic                    axi_wvalid;
  logic                    axi_wready;
  logic [DATA_WIDTH-1:0]   axi_wdata;
  logic [DATA_WIDTH/8-1:0] axi_wstrb;
  logic                    axi_bvalid;
  logic                    axi_bready;
  logic [1:0]              axi_bresp;
  logic                    axi_arvalid;
  logic                    axi_arready;
  logic [ADDR_WIDTH-1:0]   axi_araddr;
  logic [2:0]              axi_arprot;
  logic                    axi_rvalid;
  logic                    axi_rready;
  logic [DATA_WIDTH-1:0]   axi_rdata;
  logic [1:0]              axi_rresp;

  modport master (
    input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output axi_awvalid, axi_awaddr, axi_awprot, input axi_awready,
    output axi_wvalid, axi_wdata, axi_wstrb, input axi_wready,
    input  axi_bvalid, axi_bresp, output axi_bready,
    output axi_arvalid, axi_araddr, axi_arprot, input axi_arready,
    input  axi_rvalid, axi_rdata, axi_rresp, output axi_rready
  );

  modport slave (
    output req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  axi_awvalid, axi_awaddr, axi_awprot, output axi_awready,
    input  axi_wvalid, axi_wdata, axi_wstrb, output axi_wready,
    output axi_bvalid, axi_bresp, input axi_bready,
    input  axi_arvalid, axi_araddr, axi_arprot, output axi_arready,
    output axi_rvalid, axi_rdata, axi_rresp, input axi_rready
  );
endinterface

// File: rtl/axi_lite_lsu.sv
// rtl/axi_lite_lsu.sv - load/store unit bridging core data requests onto an AXI4-lite master
// One access in flight; strobes/lane shifts generated here, loads extended on return.
module axi_lite_lsu #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [2:0] AXI_PROT   = 3'b000
) (
  input  logic           clk,
  input  logic           rst_n,
  axi_lite_lsu_if.master bus
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(STRB_W);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WRESP, S_READ_ADDR, S_READ_DATA, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  bready_q, bready_d;
  logic                  rready_q, rready_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;

  logic [LANE_W-1:0]     req_lane, cur_lane;
  logic                  size_ok, aligned;
  logic [STRB_W-1:0]     byte_mask;
  logic [DATA_WIDTH-1:0] ld_shift, ld_mask, ld_result;
  logic                  ld_sign;
  logic                  unused_resp_lsb;

  assign req_lane        = bus.req_addr[LANE_W-1:0];
  assign cur_lane        = addr_q[LANE_W-1:0];
  assign unused_resp_lsb = bus.axi_bresp[0] ^ bus.axi_rresp[0];

  always_comb begin
    size_ok   = (bus.req_size != 2'd3) || (DATA_WIDTH == 64);
    aligned   = 1'b1;
    byte_mask = STRB_W'(8'h01);
    case (bus.req_size)
      2'd0: begin aligned = 1'b1;                  byte_mask = STRB_W'(8'h01); end
      2'd1: begin aligned = (req_lane[0] == 1'b0);   byte_mask = STRB_W'(8'h03); end
      2'd2: begin aligned = (req_lane[1:0] == 2'b00); byte_mask = STRB_W'(8'h0F); end
      default: begin aligned = (req_lane == '0);   byte_mask = STRB_W'(8'hFF); end
    endcase
  end

  // Load path: bring the addressed lane down to bit 0, then mask and extend.
  always_comb begin
    ld_shift = bus.axi_rdata >> {cur_lane, 3'b000};
    case (size_q)
      2'd0:    begin ld_mask = DATA_WIDTH'(8'hFF);         ld_sign = ld_shift[7];  end
      2'd1:    begin ld_mask = DATA_WIDTH'(16'hFFFF);      ld_sign = ld_shift[15]; end
      2'd2:    begin ld_mask = DATA_WIDTH'(32'hFFFF_FFFF); ld_sign = ld_shift[31]; end
      default: begin ld_mask = '1;                         ld_sign = ld_shift[DATA_WIDTH-1]; end
    endcase
    ld_result = (ld_shift & ld_mask) | ((signed_q && ld_sign) ? ~ld_mask : '0);
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    signed_d     = signed_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    arvalid_d    = arvalid_q;
    bready_d     = bready_q;
    rready_d     = rready_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d   = bus.req_addr;
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          if (!size_ok || !aligned) begin
            state_d      = S_DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (bus.req_we) begin
            state_d   = S_WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            wdata_d   = bus.req_wdata << {req_lane, 3'b000};
            wstrb_d   = byte_mask << req_lane;
          end else begin
            state_d   = S_READ_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
        // AW and W retire independently; B is only opened once both are gone.
        if (awvalid_q && bus.axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && bus.axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = S_WRESP;
          bready_d = 1'b1;
        end
      end
      S_WRESP: begin
        if (bus.axi_bvalid) begin
          state_d      = S_DONE;
          bready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = bus.axi_bresp[1];
          resp_rdata_d = '0;
        end
      end
      S_READ_ADDR: begin
        if (bus.axi_arready) begin
          state_d   = S_READ_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      S_READ_DATA: begin
        if (bus.axi_rvalid) begin
          state_d      = S_DONE;
          rready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = bus.axi_rresp[1];
          resp_rdata_d = bus.axi_rresp[1] ? '0 : ld_result;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      rready_q     <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      arvalid_q    <= arvalid_d;
      bready_q     <= bready_d;
      rready_q     <= rready_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready   = (state_q == S_IDLE);
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.axi_awvalid = awvalid_q;
  assign bus.axi_awaddr  = addr_q;
  assign bus.axi_awprot  = AXI_PROT;
  assign bus.axi_wvalid  = wvalid_q;
  assign bus.axi_wdata   = wdata_q;
  assign bus.axi_wstrb   = wstrb_q;
  assign bus.axi_bready  = bready_q;
  assign bus.axi_arvalid = arvalid_q;
  assign bus.axi_araddr  = addr_q;
  assign bus.axi_arprot  = AXI_PROT;
  assign bus.axi_rready  = rready_q;
endmodule

// File: tb/tb_axi_lite_lsu.sv
// tb/tb_axi_lite_lsu.sv - directed self-checking bench for axi_lite_lsu
// A 32-bit and a 64-bit instance share clk/rst_n; inputs change and outputs are sampled at negedge.
module tb_axi_lite_lsu;
  logic clk = 1'b0;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  axi_lite_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b32 ();
  axi_lite_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) b64 ();

  axi_lite_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .AXI_PROT(3'b000)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .bus(b32)
  );
  axi_lite_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .AXI_PROT(3'b000)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .bus(b64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue32(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wd);
    b32.req_we     = we;
    b32.req_addr   = addr;
    b32.req_size   = size;
    b32.req_signed = sgn;
    b32.req_wdata  = wd;
    b32.req_valid  = 1'b1;
    @(negedge clk);
    b32.req_valid  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    b32.req_valid = 0; b32.req_we = 0; b32.req_addr = 0; b32.req_size = 0;
    b32.req_signed = 0; b32.req_wdata = 0;
    b32.axi_awready = 0; b32.axi_wready = 0; b32.axi_bvalid = 0; b32.axi_bresp = 0;
    b32.axi_arready = 0; b32.axi_rvalid = 0; b32.axi_rdata = 0; b32.axi_rresp = 0;
    b64.req_valid = 0; b64.req_we = 0; b64.req_addr = 0; b64.req_size = 0;
    b64.req_signed = 0; b64.req_wdata = 0;
    b64.axi_awready = 0; b64.axi_wready = 0; b64.axi_bvalid = 0; b64.axi_bresp = 0;
    b64.axi_arready = 0; b64.axi_rvalid = 0; b64.axi_rdata = 0; b64.axi_rresp = 0;

    @(negedge clk);
    chk("rst_req_ready",  64'(b32.req_ready),   64'd1);
    chk("rst_resp_valid", 64'(b32.resp_valid),  64'd0);
    chk("rst_resp_rdata", 64'(b32.resp_rdata),  64'd0);
    chk("rst_resp_err",   64'(b32.resp_err),    64'd0);
    chk("rst_valids",     64'({b32.axi_awvalid, b32.axi_wvalid, b32.axi_arvalid,
                               b32.axi_bready, b32.axi_rready}), 64'd0);
    chk("rst_addr_data",  64'({b32.axi_awaddr, b32.axi_wdata}), 64'd0);
    chk("rst_wstrb",      64'(b32.axi_wstrb),   64'd0);
    chk("rst64_ready",    64'(b64.req_ready),   64'd1);
    rst_n = 1'b1;

    // store byte 0xA5 to 0x1003, zero-wait slave
    b32.axi_awready = 1; b32.axi_wready = 1;
    issue32(1'b1, 32'h1003, 2'd0, 1'b0, 32'h0000_00A5);
    chk("sb_awvalid",   64'(b32.axi_awvalid), 64'd1);
    chk("sb_wvalid",    64'(b32.axi_wvalid),  64'd1);
    chk("sb_awaddr",    64'(b32.axi_awaddr),  64'h1003);
    chk("sb_wdata",     64'(b32.axi_wdata),   64'hA500_0000);
    chk("sb_wstrb",     64'(b32.axi_wstrb),   64'h8);
    chk("sb_awprot",    64'(b32.axi_awprot),  64'd0);
    chk("sb_req_ready", 64'(b32.req_ready),   64'd0);
    @(negedge clk);
    chk("sb_aw_w_done", 64'({b32.axi_awvalid, b32.axi_wvalid}), 64'd0);
    chk("sb_bready",    64'(b32.axi_bready),  64'd1);
    b32.axi_bvalid = 1; b32.axi_bresp = 2'b00;
    @(negedge clk);
    b32.axi_bvalid = 0;
    chk("sb_resp_valid", 64'(b32.resp_valid), 64'd1);
    chk("sb_resp_err",   64'(b32.resp_err),   64'd0);
    chk("sb_bready_off", 64'(b32.axi_bready), 64'd0);
    @(negedge clk);
    chk("sb_resp_pulse", 64'(b32.resp_valid), 64'd0);
    chk("sb_ready_back", 64'(b32.req_ready),  64'd1);
    b32.axi_awready = 0; b32.axi_wready = 0;

    // load half signed from 0x2002
    b32.axi_arready = 1;
    issue32(1'b0, 32'h2002, 2'd1, 1'b1, 32'h0);
    chk("lhs_arvalid", 64'(b32.axi_arvalid), 64'd1);
    chk("lhs_araddr",  64'(b32.axi_araddr),  64'h2002);
    chk("lhs_awvalid", 64'(b32.axi_awvalid), 64'd0);
    @(negedge clk);
    chk("lhs_rready",  64'(b32.axi_rready),  64'd1);
    chk("lhs_ar_done", 64'(b32.axi_arvalid), 64'd0);
    b32.axi_rvalid = 1; b32.axi_rdata = 32'h8001_1234; b32.axi_rresp = 2'b00;
    @(negedge clk);
    b32.axi_rvalid = 0;
    chk("lhs_resp_valid", 64'(b32.resp_valid), 64'd1);
    chk("lhs_rdata",      64'(b32.resp_rdata), 64'hFFFF_8001);
    chk("lhs_err",        64'(b32.resp_err),   64'd0);
    @(negedge clk);
    chk("lhs_ready_back", 64'(b32.req_ready),  64'd1);

    // load half unsigned from 0x2002
    issue32(1'b0, 32'h2002, 2'd1, 1'b0, 32'h0);
    @(negedge clk);
    b32.axi_rvalid = 1; b32.axi_rdata = 32'h8001_1234; b32.axi_rresp = 2'b01;
    @(negedge clk);
    b32.axi_rvalid = 0;
    chk("lhu_resp_valid", 64'(b32.resp_valid), 64'd1);
    chk("lhu_rdata",      64'(b32.resp_rdata), 64'h0000_8001);
    chk("lhu_exokay_err", 64'(b32.resp_err),   64'd0);
    @(negedge clk);

    // load word with DECERR: error flagged, data forced to zero
    issue32(1'b0, 32'h0000_0060, 2'd2, 1'b0, 32'h0);
    @(negedge clk);
    b32.axi_rvalid = 1; b32.axi_rdata = 32'hDEAD_BEEF; b32.axi_rresp = 2'b11;
    @(negedge clk);
    b32.axi_rvalid = 0; b32.axi_rresp = 2'b00;
    chk("ldec_resp_valid", 64'(b32.resp_valid), 64'd1);
    chk("ldec_err",        64'(b32.resp_err),   64'd1);
    chk("ldec_rdata",      64'(b32.resp_rdata), 64'd0);
    @(negedge clk);

    // misaligned word load from 0x3001
    issue32(1'b0, 32'h3001, 2'd2, 1'b0, 32'h0);
    chk("mis_resp_valid", 64'(b32.resp_valid),  64'd1);
    chk("mis_err",        64'(b32.resp_err),    64'd1);
    chk("mis_rdata",      64'(b32.resp_rdata),  64'd0);
    chk("mis_no_ar",      64'(b32.axi_arvalid), 64'd0);
    @(negedge clk);
    chk("mis_pulse",      64'(b32.resp_valid),  64'd0);
    chk("mis_ready",      64'(b32.req_ready),   64'd1);

    // dword size on a 32-bit bus is illegal
    issue32(1'b0, 32'h0000_0010, 2'd3, 1'b0, 32'h0);
    chk("sz3_resp_valid", 64'(b32.resp_valid), 64'd1);
    chk("sz3_err",        64'(b32.resp_err),   64'd1);
    chk("sz3_no_axi",     64'({b32.axi_arvalid, b32.axi_awvalid, b32.axi_wvalid}), 64'd0);
    @(negedge clk);
    b32.axi_arready = 0;

    // store word with AW ready delayed three cycles, W immediate, SLVERR response
    b32.axi_wready = 1;
    issue32(1'b1, 32'h0000_0040, 2'd2, 1'b0, 32'h1122_3344);
    chk("sdl_c1_valids", 64'({b32.axi_awvalid, b32.axi_wvalid}), 64'd3);
    chk("sdl_wdata",     64'(b32.axi_wdata), 64'h1122_3344);
    chk("sdl_wstrb",     64'(b32.axi_wstrb), 64'hF);
    @(negedge clk);
    chk("sdl_c2_valids", 64'({b32.axi_awvalid, b32.axi_wvalid}), 64'd2);
    chk("sdl_c2_bready", 64'(b32.axi_bready), 64'd0);
    @(negedge clk);
    chk("sdl_c3_awvalid", 64'(b32.axi_awvalid), 64'd1);
    chk("sdl_c3_awaddr",  64'(b32.axi_awaddr),  64'h40);
    chk("sdl_c3_bready",  64'(b32.axi_bready),  64'd0);
    @(negedge clk);
    chk("sdl_c4_awvalid", 64'(b32.axi_awvalid), 64'd1);
    chk("sdl_c4_bready",  64'(b32.axi_bready),  64'd0);
    b32.axi_awready = 1;
    @(negedge clk);
    b32.axi_awready = 0;
    chk("sdl_c5_awvalid", 64'(b32.axi_awvalid), 64'd0);
    chk("sdl_c5_bready",  64'(b32.axi_bready),  64'd1);
    b32.axi_bvalid = 1; b32.axi_bresp = 2'b10;
    @(negedge clk);
    b32.axi_bvalid = 0; b32.axi_bresp = 2'b00;
    chk("sdl_resp_valid", 64'(b32.resp_valid), 64'd1);
    chk("sdl_err",        64'(b32.resp_err),   64'd1);
    @(negedge clk);
    b32.axi_wready = 0;

    // 64-bit bus: load dword from 0x8
    b64.axi_arready = 1;
    b64.req_we = 0; b64.req_addr = 32'h8; b64.req_size = 2'd3; b64.req_signed = 0;
    b64.req_valid = 1;
    @(negedge clk);
    b64.req_valid = 0;
    chk("ld64_arvalid", 64'(b64.axi_arvalid), 64'd1);
    chk("ld64_araddr",  64'(b64.axi_araddr),  64'h8);
    @(negedge clk);
    b64.axi_rvalid = 1; b64.axi_rdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    b64.axi_rvalid = 0;
    chk("ld64_resp_valid", 64'(b64.resp_valid), 64'd1);
    chk("ld64_rdata",      b64.resp_rdata,      64'h0123_4567_89AB_CDEF);
    chk("ld64_err",        64'(b64.resp_err),   64'd0);
    @(negedge clk);

    // 64-bit bus: signed byte from lane 5
    b64.req_addr = 32'h15; b64.req_size = 2'd0; b64.req_signed = 1;
    b64.req_valid = 1;
    @(negedge clk);
    b64.req_valid = 0;
    @(negedge clk);
    b64.axi_rvalid = 1; b64.axi_rdata = 64'h0000_8000_0000_0000;
    @(negedge clk);
    b64.axi_rvalid = 0;
    chk("lb64_rdata", b64.resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    @(negedge clk);
    b64.axi_arready = 0;

    // reset while a read address is outstanding
    issue32(1'b0, 32'h0000_0050, 2'd2, 1'b0, 32'h0);
    chk("mrst_arvalid_pre", 64'(b32.axi_arvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_arvalid_drop", 64'(b32.axi_arvalid), 64'd0);
    chk("mrst_req_ready",    64'(b32.req_ready),   64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mrst_no_resp", 64'(b32.resp_valid), 64'd0);
    end
    chk("mrst_ready_after", 64'(b32.req_ready), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/axi_lite_lsu.md
# axi_lite_lsu

Parametrised load/store unit between the CPU core's data-memory request port and an AXI4-lite master interface. It is the next generation of the core's AXI4-lite master path: configurable address/data width, byte/halfword/word(/doubleword) accesses with generated write strobes, load sign/zero extension, misalignment trapping and AXI error reporting. It sits inside the CPU top level, between the execute/memory stage and the external AXI4-lite memory ports.

## Interface
- ADDR_WIDTH, 32, AXI and request address width
- DATA_WIDTH, 32, AXI data width; 32 or 64 only
- AXI_PROT, 3'b000, constant driven on axi_awprot/axi_arprot
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  memory request valid
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  byte address
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword (dword legal only when DATA_WIDTH=64)
- req_signed  in  1  sign-extend load result
- req_wdata  in  DATA_WIDTH  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_WIDTH  extended load data (0 for stores and errors)
- resp_err  out  1  misaligned, illegal size, SLVERR or DECERR
- axi_aw{valid,ready,addr,prot}, axi_w{valid,ready,data,strb}, axi_b{valid,ready,resp}, axi_ar{valid,ready,addr,prot}, axi_r{valid,ready,data,resp}: standard AXI4-lite master, widths per ADDR_WIDTH/DATA_WIDTH, strb DATA_WIDTH/8, resp 2

## Operation
- States: IDLE, WRITE (AW/W outstanding), WRESP, READ_ADDR, READ_DATA, DONE.
- req_ready = (state == IDLE). Request accepted on req_valid && req_ready; all request fields captured in registers.
- Lane = req_addr[log2(DATA_WIDTH/8)-1:0]. Aligned iff lane is a multiple of 2^req_size.
- Misaligned or illegal size: IDLE -> DONE, no AXI traffic, resp_err=1.
- Store: IDLE -> WRITE; axi_awvalid and axi_wvalid both assert. Each deasserts independently on its own handshake; when both done -> WRESP. axi_awaddr = captured address (unaligned low bits kept). axi_wdata = req_wdata << (8*lane); axi_wstrb = ((1<<2^size)-1) << lane.
- WRESP: axi_bready=1; on axi_bvalid -> DONE, resp_err = axi_bresp[1].
- Load: IDLE -> READ_ADDR (axi_arvalid=1) -> on axi_arready READ_DATA (axi_rready=1) -> on axi_rvalid DONE. Data = axi_rdata >> (8*lane), masked to 2^size bytes, sign-extended from the top bit if req_signed else zero-extended; resp_err = axi_rresp[1]; rdata forced 0 on error.
- DONE: resp_valid=1 for exactly one cycle, then IDLE.
- OKAY and EXOKAY both treated as success.

## Timing
- Reset (async, immediate): state IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0; all axi_*valid and axi_bready/axi_rready=0; addr/data/strb=0. Reset mid-transaction drops all valids without completing; no response issued.
- All AXI outputs and resp_* registered. Request accepted at cycle N -> AXI valids high at N+1.
- Zero-wait slave (ready/valid same cycle): store resp_valid at N+3, load resp_valid at N+3; misaligned resp_valid at N+1.
- Valid signals, address, data, strobe held stable until handshake; never withdrawn.
- AW and W may complete in either order or same cycle; B not accepted before both complete.
- req_ready low from N+1 through the resp_valid cycle; next request accepted earliest the cycle after resp_valid.

## Test plan
- DATA_WIDTH=32, store byte 0xA5 to 0x1003 -> awaddr 0x1003, wdata 0xA5000000, wstrb 4'b1000, resp_valid at N+3, resp_err=0.
- Load half signed from 0x2002, rdata 0x8001_1234 -> resp_rdata 0xFFFF8001; unsigned -> 0x00008001.
- Load word from 0x3001 -> no arvalid, resp_valid at N+1, resp_err=1, rdata 0.
- Store with awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4, bready only after both; bresp=2'b10 -> resp_err=1.
- DATA_WIDTH=64, load dword from 0x8 with rdata 0x0123456789ABCDEF -> exact value returned; size 3 at DATA_WIDTH=32 -> resp_err=1, no AXI traffic.
- Assert rst_n low while arvalid high -> arvalid 0 immediately, req_ready=1 after release, no resp_valid.
